// File: rtl/modinv_par_pkg.sv
// Shared types and helpers for the binary extended-GCD modular inverse/divide unit.
// Holds the FSM state encoding, the load target codes and the iteration counter width.
package modinv_par_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INIT = 2'b01,
        ITER = 2'b10,
        FIN  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_P    = 2'b01,
        SEL_B    = 2'b10,
        SEL_NONE = 2'b11
    } load_sel_e;

    // One extra bit so the counter can hold the full 4*WIDTH iteration budget.
    function automatic int cnt_width(input int width);
        return $clog2(4 * width) + 1;
    endfunction

endpackage

// File: rtl/modinv_halve.sv
// Modular halving: y = x/2 when x is even, (x+p)/2 when x is odd.
// The sum is formed on WIDTH+1 bits; since x < p the result fits back into WIDTH bits.
module modinv_halve
    import modinv_par_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, x_i} + (x_i[0] ? {1'b0, p_i} : {(WIDTH+1){1'b0}});
        y_o = sum[WIDTH:1];
    end

endmodule

// File: rtl/modinv_par.sv
// Modular inverse (a^-1 mod p) or division (b*a^-1 mod p) using the binary extended
// Euclidean algorithm, one reduction step per cycle, with word-serial load and readout.
module modinv_par
    import modinv_par_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          load,
    input  logic [1:0]    load_sel,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    localparam int NW = WIDTH / DW;
    localparam int PW = $clog2(NW);
    localparam int CW = cnt_width(WIDTH);

    localparam logic [CW-1:0]    ITER_LAST = CW'(4 * WIDTH - 1);
    localparam logic [PW-1:0]    PTR_LAST  = PW'(NW - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE     = WIDTH'(3);

    state_e state_q, state_d;

    logic mode_q, mode_d;
    logic fail_q, fail_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic doutValid_q, doutValid_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [CW-1:0] iterCnt_q, iterCnt_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0] x1Half, x2Half;
    logic [WIDTH:0]   diff12, diff21;
    logic [WIDTH-1:0] sub12, sub21;

    modinv_halve #(.WIDTH(WIDTH)) u_halveX1 (
        .x_i (x1_q),
        .p_i (p_q),
        .y_o (x1Half)
    );

    modinv_halve #(.WIDTH(WIDTH)) u_halveX2 (
        .x_i (x2_q),
        .p_i (p_q),
        .y_o (x2Half)
    );

    // A borrow out of the WIDTH+1-bit difference means the result went negative; add p back.
    assign diff12 = {1'b0, x1_q} - {1'b0, x2_q};
    assign diff21 = {1'b0, x2_q} - {1'b0, x1_q};
    assign sub12  = diff12[WIDTH] ? (diff12[WIDTH-1:0] + p_q) : diff12[WIDTH-1:0];
    assign sub21  = diff21[WIDTH] ? (diff21[WIDTH-1:0] + p_q) : diff21[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        doutValid_d = doutValid_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        u_d         = u_q;
        v_d         = v_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        result_d    = result_q;
        iterCnt_d   = iterCnt_q;
        ptr_d       = ptr_q;

        if (rd && doutValid_q) begin
            if (ptr_q == PTR_LAST) begin
                doutValid_d = 1'b0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    case (load_sel_e'(load_sel))
                        SEL_A:    a_d = {din, a_q[WIDTH-1:DW]};
                        SEL_P:    p_d = {din, p_q[WIDTH-1:DW]};
                        SEL_B:    b_d = {din, b_q[WIDTH-1:DW]};
                        SEL_NONE: ;
                        default:  ;
                    endcase
                end
                // Operands are captured from the current registers, so a same-cycle load
                // only affects the next operation.
                if (start) begin
                    state_d     = INIT;
                    mode_d      = mode;
                    fail_d      = 1'b0;
                    u_d         = a_q;
                    v_d         = p_q;
                    x1_d        = mode ? b_q : ONE;
                    x2_d        = '0;
                    iterCnt_d   = '0;
                    doutValid_d = 1'b0;
                    ptr_d       = '0;
                end
            end

            INIT: begin
                state_d = ITER;
                if (!v_q[0] || (v_q < THREE) || (u_q == '0) || (u_q >= v_q) ||
                    (mode_q && (x1_q >= v_q))) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end
            end

            ITER: begin
                iterCnt_d = iterCnt_q + CW'(1);
                if ((u_q == ONE) || (v_q == ONE)) begin
                    state_d = FIN;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        x1_d = x1Half;
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        x2_d = x2Half;
                    end else if (u_q >= v_q) begin
                        u_d  = u_q - v_q;
                        x1_d = sub12;
                    end else begin
                        v_d  = v_q - u_q;
                        x2_d = sub21;
                    end
                    if (iterCnt_q == ITER_LAST) begin
                        fail_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
                ptr_d   = '0;
                if (fail_q) begin
                    err_d       = 1'b1;
                    result_d    = '0;
                    doutValid_d = 1'b0;
                end else begin
                    done_d      = 1'b1;
                    result_d    = (u_q == ONE) ? x1_q : x2_q;
                    doutValid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            doutValid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            u_q         <= '0;
            v_q         <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            result_q    <= '0;
            iterCnt_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            err_q       <= err_d;
            doutValid_q <= doutValid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            u_q         <= u_d;
            v_q         <= v_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            result_q    <= result_d;
            iterCnt_q   <= iterCnt_d;
            ptr_q       <= ptr_d;
        end
    end

    // done/err pulse in the cycle after FIN, so busy is stretched to cover that cycle.
    assign busy       = (state_q != IDLE) || done_q || err_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dout_valid = doutValid_q;
    assign dout       = doutValid_q ? result_q[int'(ptr_q) * DW +: DW] : '0;

endmodule

// File: tb/tb_modinv_par.sv
// Scoreboard bench for modinv_par at WIDTH=16, DW=8: stimulus pushes hand-computed
// expectations, an independent monitor pops them whenever done or err appears.
module tb_modinv_par;

    localparam int WIDTH = 16;
    localparam int DW    = 8;
    localparam int NW    = WIDTH / DW;
    localparam int MAX_LAT = 2 + 4 * WIDTH + 1;

    typedef struct {
        string       name;
        bit          isErr;
        logic [15:0] value;
        int          lat;
        int          startCycle;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic          load;
    logic [1:0]    loadSel;
    logic [DW-1:0] din;
    logic          rd;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] dout;
    logic          doutValid;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleCount = 0;

    modinv_par #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .load       (load),
        .load_sel   (loadSel),
        .din        (din),
        .rd         (rd),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dout       (dout),
        .dout_valid (doutValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadReg(input logic [1:0] sel, input logic [15:0] value);
        for (int i = 0; i < NW; i++) begin
            @(posedge clk); #1;
            load    = 1'b1;
            loadSel = sel;
            din     = value[i*DW +: DW];
        end
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pushExp(input string name, input bit isErr, input logic [15:0] value, input int lat);
        exp_t e;
        e.name       = name;
        e.isErr      = isErr;
        e.value      = value;
        e.lat        = lat;
        e.startCycle = cycleCount;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic m, input bit isErr,
                                 input logic [15:0] value, input int lat);
        @(posedge clk); #1;
        pushExp(name, isErr, value, lat);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(done || err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL %s timeout: no done/err after %0d cycles, required within %0d", name, n, MAX_LAT);
        end
        repeat (6) @(posedge clk);
    endtask

    // Monitor: owns rd, drains every result and compares against the queue head.
    initial begin
        exp_t        e;
        logic [15:0] got;
        int          lat;
        rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (done || err)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected completion: done=%0b err=%0b, required no completion", done, err);
                end else begin
                    e   = expQ.pop_front();
                    lat = cycleCount - e.startCycle;
                    checkOutput({e.name, " done/err"}, {30'd0, done, err}, e.isErr ? 32'd1 : 32'd2);
                    checkOutput({e.name, " busy"}, {31'd0, busy}, 32'd1);
                    checkOutput({e.name, " latency"}, lat, e.lat);
                    checkOutput({e.name, " latency bound"}, {31'd0, lat > MAX_LAT}, 32'd0);
                    if (e.isErr) begin
                        checkOutput({e.name, " dout_valid"}, {31'd0, doutValid}, 32'd0);
                        checkOutput({e.name, " dout"}, {24'd0, dout}, 32'd0);
                    end else begin
                        checkOutput({e.name, " dout_valid"}, {31'd0, doutValid}, 32'd1);
                        got[DW-1:0] = dout;
                        rd = 1'b1;
                        for (int i = 1; i < NW; i++) begin
                            @(negedge clk);
                            got[i*DW +: DW] = dout;
                        end
                        checkOutput({e.name, " result"}, {16'd0, got}, {16'd0, e.value});
                        for (int k = 0; k < 2; k++) begin
                            @(negedge clk);
                            checkOutput({e.name, " drained valid"}, {31'd0, doutValid}, 32'd0);
                            checkOutput({e.name, " drained dout"}, {24'd0, dout}, 32'd0);
                        end
                        rd = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        load    = 1'b0;
        loadSel = 2'b00;
        din     = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset dout_valid", {31'd0, doutValid}, 32'd0);
        checkOutput("reset dout", {24'd0, dout}, 32'd0);
        rst = 1'b1;

        loadReg(2'b01, 16'd17);
        loadReg(2'b00, 16'd3);
        applyStimulus("inv3mod17", 1'b0, 1'b0, 16'd6, 9);
        waitDone("inv3mod17");

        loadReg(2'b10, 16'd5);
        applyStimulus("div5by3mod17", 1'b1, 1'b0, 16'd13, 9);
        waitDone("div5by3mod17");

        loadReg(2'b10, 16'd17);
        applyStimulus("b>=p", 1'b1, 1'b1, 16'd0, 3);
        waitDone("b>=p");

        loadReg(2'b00, 16'd0);
        applyStimulus("a=0", 1'b0, 1'b1, 16'd0, 3);
        waitDone("a=0");

        loadReg(2'b00, 16'd17);
        applyStimulus("a=p", 1'b0, 1'b1, 16'd0, 3);
        waitDone("a=p");

        loadReg(2'b01, 16'd16);
        loadReg(2'b00, 16'd3);
        applyStimulus("p even", 1'b0, 1'b1, 16'd0, 3);
        waitDone("p even");

        loadReg(2'b01, 16'd15);
        loadReg(2'b00, 16'd5);
        applyStimulus("gcd5mod15", 1'b0, 1'b1, 16'd0, 7);
        waitDone("gcd5mod15");

        loadReg(2'b01, 16'd17);
        loadReg(2'b00, 16'd1);
        applyStimulus("inv1mod17", 1'b0, 1'b0, 16'd1, 4);
        waitDone("inv1mod17");

        loadReg(2'b00, 16'd16);
        applyStimulus("inv16mod17", 1'b0, 1'b0, 16'd16, 8);
        waitDone("inv16mod17");

        loadReg(2'b00, 16'd4);
        loadReg(2'b10, 16'd1);
        applyStimulus("div1by4mod17", 1'b1, 1'b0, 16'd13, 6);
        waitDone("div1by4mod17");

        loadReg(2'b01, 16'd65521);
        loadReg(2'b00, 16'd2);
        applyStimulus("inv2mod65521", 1'b0, 1'b0, 16'd32761, 5);
        waitDone("inv2mod65521");

        // start and load while busy must not disturb the running operation or the operands
        loadReg(2'b01, 16'd17);
        loadReg(2'b00, 16'd3);
        applyStimulus("busyStart", 1'b0, 1'b0, 16'd6, 9);
        repeat (2) @(posedge clk);
        #1;
        start   = 1'b1;
        mode    = 1'b1;
        load    = 1'b1;
        loadSel = 2'b00;
        din     = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        load  = 1'b0;
        waitDone("busyStart");
        applyStimulus("retained", 1'b0, 1'b0, 16'd6, 9);
        waitDone("retained");

        // start and load together: start uses a=3, the load leaves a=0x5500 afterwards
        @(posedge clk); #1;
        pushExp("startWithLoad", 1'b0, 16'd6, 9);
        start   = 1'b1;
        mode    = 1'b0;
        load    = 1'b1;
        loadSel = 2'b00;
        din     = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        load  = 1'b0;
        waitDone("startWithLoad");
        applyStimulus("afterLoad a>=p", 1'b0, 1'b1, 16'd0, 3);
        waitDone("afterLoad a>=p");

        // reset in the middle of ITER: no completion, registers cleared
        loadReg(2'b01, 16'd97);
        loadReg(2'b00, 16'd96);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midReset busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset done", {31'd0, done}, 32'd0);
        checkOutput("midReset err", {31'd0, err}, 32'd0);
        checkOutput("midReset dout_valid", {31'd0, doutValid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus("cleared p", 1'b0, 1'b1, 16'd0, 3);
        waitDone("cleared p");
        loadReg(2'b01, 16'd97);
        loadReg(2'b00, 16'd96);
        applyStimulus("inv96mod97", 1'b0, 1'b0, 16'd96, 18);
        waitDone("inv96mod97");

        repeat (5) @(posedge clk);
        checkOutput("pending expectations", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modinv_par.md
MODINV_PAR -- requirements
Module: modinv_par

Interface
REQ-001 Parameter WIDTH, default 256, operand/modulus width in bits (multiple of DW, >= 2*DW).
REQ-002 Parameter DW, default 16, load/readout word width in bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 start  input  1  one-cycle pulse; begins operation when idle.
REQ-006 mode  input  1  0 = inverse a^-1 mod p; 1 = division b*a^-1 mod p (latched at start).
REQ-007 load  input  1  writes din into register chosen by load_sel.
REQ-008 load_sel  input  2  00 = a, 01 = p, 10 = b, 11 = ignored.
REQ-009 din  input  DW  load data, least-significant word first.
REQ-010 rd  input  1  pops one result word.
REQ-011 busy  output  1  high from cycle after accepted start until done/err cycle inclusive.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 err  output  1  one-cycle pulse, no inverse exists or bad operands.
REQ-014 dout  output  DW  current result word, LSW first.
REQ-015 dout_valid  output  1  high while unread result words remain.

Function
REQ-016 FSM states IDLE, INIT, ITER, FIN; IDLE->INIT on start, INIT->ITER, ITER->FIN on termination, FIN->IDLE next cycle.
REQ-017 load in IDLE: selected register right-shifts by DW, din enters top word; WIDTH/DW loads fill it; load outside IDLE ignored.
REQ-018 start while not IDLE ignored; start and load same cycle: load takes effect, start uses pre-load values.
REQ-019 INIT: u=a, v=p, x1=(mode ? b : 1), x2=0; if p even, p<3, a=0 or a>=p, or (mode=1 and b>=p) -> FIN with err.
REQ-020 ITER per cycle, first matching rule: u=1 or v=1 -> terminate ok; u=0 or v=0 -> terminate err; u even -> u=u/2, x1=halve(x1); v even -> v=v/2, x2=halve(x2); u>=v -> u=u-v, x1=(x1-x2) mod p; else v=v-u, x2=(x2-x1) mod p.
REQ-021 halve(x) = x/2 if x even, else (x+p)/2 computed on WIDTH+1 bits; modular subtract adds p when borrow; all x values stay in [0,p-1].
REQ-022 Iteration counter (width clog2(4*WIDTH)+1) aborts ITER with err at 4*WIDTH cycles.
REQ-023 FIN ok: result register = (u=1 ? x1 : x2), done=1, dout_valid=1, word pointer=0; FIN err: err=1, result cleared, dout_valid=0.
REQ-024 Latency start-to-done = 2 + ITER cycle count + 1; exactly one of done/err per accepted start.
REQ-025 dout = result word at pointer; rd with dout_valid=1 advances pointer; after last word dout_valid=0; rd with dout_valid=0 ignored.
REQ-026 Accepted start clears dout_valid; unread words discarded.
REQ-027 a, b, p retained after operation; repeated start reuses them.

Reset
REQ-028 rst=0: state IDLE, busy=0, done=0, err=0, dout_valid=0, dout=0, pointer=0, u, v, x1, x2, a, b, p, result=0.
REQ-029 Reset mid-ITER aborts immediately; no done/err issued afterwards.

Structure
REQ-030 Shared package holds state enum, load_sel codes, and function for counter width.
REQ-031 One sub-module modinv_halve (combinational (x+p*odd)/2 on WIDTH+1 bits), instantiated twice; subtract/compare inline.

Verification
REQ-032 WIDTH=16, DW=8, p=17, a=3, mode=0 -> done, dout words 0x06, 0x00.
REQ-033 Same, mode=1, b=5 -> result 13 (0x0D, 0x00).
REQ-034 p=17, a=0 -> err pulse at INIT+1, dout_valid=0; p=16 -> err.
REQ-035 WIDTH=256, DW=16, p=P-256 prime, 200 random a, both modes -> results match golden model, latency <= 2+4*WIDTH+1.
REQ-036 rst low 10 cycles into ITER, release, restart p=97, a=96 -> single done, result 96.
REQ-037 start while busy, load while busy, rd past last word -> no effect on result or outputs.
